// File: rtl/instr_encode_pkg.sv
// Shared RV32I encoder/decoder definitions: opcodes, instruction classes, immediate field widths.
// The range-check helper is only referenced when ENCODER_RANGE_CHECK_EN is defined.
package instr_encode_pkg;

    typedef enum logic [2:0] {
        OP_R       = 3'd0,
        OP_I       = 3'd1,
        OP_LOAD    = 3'd2,
        OP_STORE   = 3'd3,
        OP_BRANCH  = 3'd4,
        OP_JAL     = 3'd5,
        OP_JALR    = 3'd6,
        OP_INVALID = 3'd7
    } op_class_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] FUNCT7_ALT = 7'h20;

    localparam int IMM_W_I = 12;
    localparam int IMM_W_S = 12;
    localparam int IMM_W_B = 13;
    localparam int IMM_W_J = 21;

    // True when every bit from the field's sign position upward matches bit 31.
    function automatic logic fits_signed(input logic [31:0] imm, input int width);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= width - 1 && imm[i] != imm[31]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_encode_if.sv
// Field-bundle input and encoded-word output bus of the instruction encoder.
// slave is the encoder's view; master is the producer/loader side.
interface instr_encode_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [2:0]        in_funct3;
    logic              in_alt;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic [ADDR_W:0]   instr_count;
    logic              err_invalid;
    logic              err_range;
    logic              err_align;

    modport slave (
        input  in_valid, in_op, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, instr_count,
        output err_invalid, err_range, err_align
    );

    modport master (
        output in_valid, in_op, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, instr_count,
        input  err_invalid, err_range, err_align
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I field packing; flags class 7 as invalid.
// With ENCODER_RANGE_CHECK_EN it also reports immediate range and alignment faults.
module instr_pack
    import instr_encode_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [2:0]  i_funct3,
    input  logic        i_alt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
`ifdef ENCODER_RANGE_CHECK_EN
    output logic        o_rangeErr,
    output logic        o_alignErr,
`endif
    output logic [31:0] o_instr,
    output logic        o_invalid
);

    op_class_e   w_op;
    logic        w_isShift;
    logic [6:0]  w_funct7;
    logic [11:0] w_iImm;

    assign w_op      = op_class_e'(i_op);
    assign w_funct7  = i_alt ? FUNCT7_ALT : 7'h00;
    assign w_isShift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    // Shift amounts carry the arithmetic/logical selector in imm[11:5].
    assign w_iImm    = w_isShift ? {w_funct7, i_imm[4:0]} : i_imm[11:0];

    always_comb begin
        o_instr   = 32'h0;
        o_invalid = 1'b0;
        case (w_op)
            OP_R:      o_instr = {w_funct7, i_rs2, i_rs1, i_funct3, i_rd, OPC_R};
            OP_I:      o_instr = {w_iImm, i_rs1, i_funct3, i_rd, OPC_OP_IMM};
            OP_LOAD:   o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_LOAD};
            OP_STORE:  o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPC_STORE};
            OP_BRANCH: o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                                  i_imm[4:1], i_imm[11], OPC_BRANCH};
            OP_JAL:    o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
            OP_JALR:   o_instr = {i_imm[11:0], i_rs1, 3'b000, i_rd, OPC_JALR};
            default:   o_invalid = 1'b1;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    always_comb begin
        o_rangeErr = 1'b0;
        o_alignErr = 1'b0;
        case (w_op)
            OP_I, OP_LOAD, OP_JALR: o_rangeErr = !fits_signed(i_imm, IMM_W_I);
            OP_STORE:               o_rangeErr = !fits_signed(i_imm, IMM_W_S);
            OP_BRANCH: begin
                o_rangeErr = !fits_signed(i_imm, IMM_W_B);
                o_alignErr = i_imm[0];
            end
            OP_JAL: begin
                o_rangeErr = !fits_signed(i_imm, IMM_W_J);
                o_alignErr = i_imm[0];
            end
            default: ;
        endcase
    end
`else
    logic w_unusedImm;
    assign w_unusedImm = ^i_imm[31:21];
`endif

endmodule

// File: rtl/instr_encode.sv
// RV32I instruction encoder: one-entry output register, word address counter, saturating count, sticky errors.
// Optional immediate range/alignment checking is enabled by defining ENCODER_RANGE_CHECK_EN.
module instr_encode
    import instr_encode_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    instr_encode_if.slave bus
);

    logic              r_outValid;
    logic [31:0]       r_outInstr;
    logic [ADDR_W-1:0] r_outAddr;
    logic [ADDR_W-1:0] r_addrCnt;
    logic [ADDR_W:0]   r_count;
    logic              r_errInvalid;

    logic              w_inReady;
    logic              w_inFire;
    logic              w_outFire;
    logic [ADDR_W-1:0] w_nextAddr;
    logic [31:0]       w_instr;
    logic              w_invalid;

    // restart and rst both block acceptance and suppress the output handshake in their cycle.
    assign w_inReady  = !rst && !restart && (!r_outValid || bus.out_ready);
    assign w_inFire   = bus.in_valid && w_inReady;
    assign w_outFire  = r_outValid && bus.out_ready && !rst && !restart;
    assign w_nextAddr = w_outFire ? r_addrCnt + ADDR_W'(1) : r_addrCnt;

`ifdef ENCODER_RANGE_CHECK_EN
    logic w_rangeErr;
    logic w_alignErr;
    logic r_errRange;
    logic r_errAlign;
`endif

    instr_pack u_pack (
        .i_op       (bus.in_op),
        .i_funct3   (bus.in_funct3),
        .i_alt      (bus.in_alt),
        .i_rd       (bus.in_rd),
        .i_rs1      (bus.in_rs1),
        .i_rs2      (bus.in_rs2),
        .i_imm      (bus.in_imm),
`ifdef ENCODER_RANGE_CHECK_EN
        .o_rangeErr (w_rangeErr),
        .o_alignErr (w_alignErr),
`endif
        .o_instr    (w_instr),
        .o_invalid  (w_invalid)
    );

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_outValid   <= 1'b0;
            r_outInstr   <= 32'h0;
            r_outAddr    <= '0;
            r_addrCnt    <= '0;
            r_count      <= '0;
            r_errInvalid <= 1'b0;
        end else begin
            if (w_outFire) begin
                r_addrCnt <= w_nextAddr;
                if (r_count != {(ADDR_W+1){1'b1}}) begin
                    r_count <= r_count + (ADDR_W+1)'(1);
                end
            end
            // An invalid class is consumed without producing a word.
            if (w_inFire && !w_invalid) begin
                r_outValid <= 1'b1;
                r_outInstr <= w_instr;
                r_outAddr  <= w_nextAddr;
            end else if (w_outFire) begin
                r_outValid <= 1'b0;
            end
            if (w_inFire && w_invalid) begin
                r_errInvalid <= 1'b1;
            end
        end
    end

`ifdef ENCODER_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_errRange <= 1'b0;
            r_errAlign <= 1'b0;
        end else if (w_inFire && !w_invalid) begin
            if (w_rangeErr) r_errRange <= 1'b1;
            if (w_alignErr) r_errAlign <= 1'b1;
        end
    end

    assign bus.err_range = r_errRange;
    assign bus.err_align = r_errAlign;
`else
    assign bus.err_range = 1'b0;
    assign bus.err_align = 1'b0;
`endif

    assign bus.in_ready    = w_inReady;
    assign bus.out_valid   = r_outValid;
    assign bus.out_instr   = r_outInstr;
    assign bus.out_addr    = r_outAddr;
    assign bus.instr_count = r_count;
    assign bus.err_invalid = r_errInvalid;

endmodule

// File: doc/instr_encode.md
INSTR_ENCODE -- requirements
Module: instr_encode

Interface
REQ-001 Parameter: ADDR_W, 10, width of the word address written alongside each encoded instruction.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: restart  input  1  clears address counter, count and sticky flags (same effect as rst).
REQ-005 Port: in_valid  input  1  field bundle present.
REQ-006 Port: in_ready  output  1  encoder can accept the bundle this cycle.
REQ-007 Port: in_op  input  3  instruction class: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 invalid.
REQ-008 Port: in_funct3  input  3  funct3 field.
REQ-009 Port: in_alt  input  1  selects funct7 = 0x20 for R-type, or imm[11:5] = 0x20 for I-type shifts (funct3 101).
REQ-010 Port: in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-011 Port: in_imm  input  32  signed immediate / byte offset.
REQ-012 Port: out_valid  output  1  encoded word held.
REQ-013 Port: out_ready  input  1  downstream (instruction memory loader) accepts the word.
REQ-014 Port: out_instr  output  32  encoded RV32I instruction.
REQ-015 Port: out_addr  output  ADDR_W  word address for out_instr.
REQ-016 Port: instr_count  output  ADDR_W+1  number of words accepted downstream since reset/restart.
REQ-017 Port: err_invalid, err_range, err_align  output  1 each  sticky error flags.

Function
REQ-018 Input handshake shall complete when in_valid && in_ready; output handshake shall complete when out_valid && out_ready.
REQ-019 in_ready shall equal !out_valid || out_ready (one-entry output register, full throughput).
REQ-020 Latency shall be one cycle: a bundle accepted at edge N shall appear on out_instr/out_valid after edge N.
REQ-021 Encoding shall follow RV32I formats: R (0110011), I (0010011), LOAD (0000011, I-format), STORE (0100011, S), BRANCH (1100011, B), JAL (1101111, J), JALR (1100111, I, funct3 forced 000).
REQ-022 For I-type with funct3 001 or 101, imm[11:5] shall be in_alt?0x20:0x00 and imm[4:0] = in_imm[4:0].
REQ-023 in_op = 7 shall be accepted and dropped: no output word, err_invalid set, counters unchanged.
REQ-024 out_addr shall hold the address counter value at encode time; the counter shall increment by 1 on each output handshake and wrap from 2^ADDR_W-1 to 0.
REQ-025 instr_count shall increment on each output handshake and saturate at 2^(ADDR_W+1)-1.
REQ-026 Simultaneous output handshake and input handshake shall replace the held word in the same cycle with no bubble.
REQ-027 restart shall take priority over both handshakes in its cycle: out_valid cleared, counter/count/flags zeroed, input not accepted (in_ready low that cycle).
REQ-028 out_instr shall be stable while out_valid && !out_ready.

Reset
REQ-029 On rst: out_valid 0, out_instr 0, out_addr 0, instr_count 0, all err_* 0; in_ready 0 during the reset cycle, 1 the first cycle after.
REQ-030 Reset asserted mid-transfer shall discard the held word without producing an output handshake.

Configuration
REQ-031 Macro ENCODER_RANGE_CHECK_EN: when defined, err_range shall set if in_imm does not fit the format's signed field (12-bit I/S, 13-bit B, 21-bit J) and err_align shall set if a B/J immediate has bit0 = 1; the word is still emitted, truncated.
REQ-032 Without ENCODER_RANGE_CHECK_EN, err_range and err_align shall be tied 0 and no check logic built.

Structure
REQ-033 Opcode constants, in_op class enum and format field widths shall live in the shared package used by the decoder.
REQ-034 Combinational field packing shall be a sub-module instr_pack; instr_encode holds the handshake, counters and flags.

Verification
REQ-035 add x3,x1,x2 (op 0, f3 0, alt 0) -> 0x002081B3 at addr 0; sub (alt 1) -> 0x402081B3 at addr 1.
REQ-036 addi x1,x0,5 -> 0x00500093; sw x2,8(x1) -> 0x0020A423.
REQ-037 out_ready held low 3 cycles with in_valid high -> in_ready low, out_instr stable, no loss, then back-to-back words at addrs N, N+1.
REQ-038 in_op 7 between two valid ops -> err_invalid 1, second word gets consecutive address.
REQ-039 ADDR_W=2, 5 words -> out_addr 0,1,2,3,0; instr_count 5.
REQ-040 With macro, addi imm 2048 -> err_range 1; beq imm 3 -> err_align 1; restart -> flags 0, next word addr 0.
